// File: rtl/store_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : store_packer_pkg
//  Brief   : Store-op encodings, byte-enable constants and the buffered store
//            entry layout shared by the store packer and the load-extend unit.
//  Rev     : 1.0  initial release
// ============================================================================
package store_packer_pkg;

    // MEM-stage store opcode; 2'b11 is reserved and always faults.
    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } store_op_e;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HI    = 4'b1100;
    localparam logic [3:0] BE_LO    = 4'b0011;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_NONE  = 4'b0000;

    // One buffered store: word address, lane-replicated data, byte enables.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

    localparam int ENTRY_W = $bits(store_entry_t);

endpackage : store_packer_pkg
`default_nettype wire

// File: rtl/store_packer_if.sv
`default_nettype none
// ============================================================================
//  Module  : store_packer_if
//  Brief   : MEM-stage request, data-memory drain and exception signals of the
//            store packer. "master" is the pipeline/memory side, "slave" is
//            the packer itself.
//  Rev     : 1.0  initial release
// ============================================================================
interface store_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    logic        exc_ades;
    logic [31:0] exc_addr;
    logic        empty;

    modport master (
        output in_valid, in_op, in_addr, in_data, mem_ack,
        input  in_ready, mem_req, mem_addr, mem_wdata, mem_be,
        input  exc_ades, exc_addr, empty
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_data, mem_ack,
        output in_ready, mem_req, mem_addr, mem_wdata, mem_be,
        output exc_ades, exc_addr, empty
    );

endinterface : store_packer_if
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : store_fifo
//  Brief   : Generic circular-buffer FIFO, DEPTH x WIDTH, with push/pop and
//            full/empty flags. Head is read straight from the storage array.
//  Rev     : 1.0  initial release
// ============================================================================
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 66
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("store_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Overflow/underflow requests are dropped here so the pointers never skew.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    // Pointer/count next state; power-of-two depth makes the wrap implicit.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : store_fifo
`default_nettype wire

// File: rtl/store_packer.sv
`default_nettype none
// ============================================================================
//  Module  : store_packer
//  Brief   : Store narrowing/alignment unit. Checks alignment, replicates the
//            narrowed operand across byte lanes, builds byte enables, buffers
//            legal stores and drains them to data memory over req/ack.
//            Misaligned or reserved stores raise a one-cycle address error.
//  Rev     : 1.0  initial release
// ============================================================================
module store_packer
    import store_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    store_packer_if.slave bus
);

    store_entry_t pack_entry;
    logic         pack_legal;
    store_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         fault;
    logic         push;
    logic         pop;

    logic         exc_ades_q, exc_ades_d;
    logic [31:0]  exc_addr_q, exc_addr_d;

    // Narrow, replicate and enable lanes for the incoming request; also legality.
    always_comb begin
        pack_entry       = '0;
        pack_legal       = 1'b0;
        pack_entry.waddr = bus.in_addr[31:2];
        case (store_op_e'(bus.in_op))
            OP_SW: begin
                pack_entry.wdata = bus.in_data;
                pack_entry.be    = BE_WORD;
                pack_legal       = (bus.in_addr[1:0] == 2'b00);
            end
            OP_SH: begin
                pack_entry.wdata = {2{bus.in_data[15:0]}};
                pack_entry.be    = bus.in_addr[1] ? BE_HI : BE_LO;
                pack_legal       = !bus.in_addr[0];
            end
            OP_SB: begin
                pack_entry.wdata = {4{bus.in_data[7:0]}};
                pack_entry.be    = BE_BYTE0 << bus.in_addr[1:0];
                pack_legal       = 1'b1;
            end
            default: begin
                pack_entry.be    = BE_NONE;
                pack_legal       = 1'b0;
            end
        endcase
    end

    // in_ready has no pop bypass, so a full buffer never accepts.
    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && !fifo_full;
    assign push         = accept && pack_legal;
    assign fault        = accept && !pack_legal;
    assign pop          = !fifo_empty && bus.mem_ack;

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (pack_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Head is only presented while valid so stale slots never leak onto the bus.
    assign bus.mem_req   = !fifo_empty;
    assign bus.mem_addr  = fifo_empty ? 32'h0   : {head.waddr, 2'b00};
    assign bus.mem_wdata = fifo_empty ? 32'h0   : head.wdata;
    assign bus.mem_be    = fifo_empty ? BE_NONE : head.be;
    assign bus.empty     = fifo_empty;

    // Exception next state: pulse follows each fault, address held until the next.
    always_comb begin
        exc_ades_d = fault;
        exc_addr_d = fault ? bus.in_addr : exc_addr_q;
    end

    // Exception registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_ades_q <= 1'b0;
            exc_addr_q <= 32'h0;
        end else begin
            exc_ades_q <= exc_ades_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign bus.exc_ades = exc_ades_q;
    assign bus.exc_addr = exc_addr_q;

endmodule : store_packer
`default_nettype wire

// File: tb/tb_store_packer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_store_packer
//  Brief   : Self-checking bench for store_packer with a queue scoreboard of
//            expected memory writes and an occupancy/exception model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_store_packer;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    store_packer_if bus ();

    store_packer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        sb[$];
    int          mcount;
    logic        exp_exc;
    logic [31:0] exp_exc_addr;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packing model written directly from the store rules.
    function automatic logic model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] d, output exp_t e);
        logic lg;
        e.addr = {a[31:2], 2'b00};
        case (op)
            2'b00: begin e.wdata = d;              e.be = 4'b1111;                     lg = (a[1:0] == 2'b00); end
            2'b01: begin e.wdata = {d[15:0], d[15:0]}; e.be = a[1] ? 4'b1100 : 4'b0011; lg = !a[0]; end
            2'b10: begin e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                         e.be = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                                (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;               lg = 1'b1; end
            default: begin e.wdata = 32'h0; e.be = 4'b0000;                        lg = 1'b0; end
        endcase
        return lg;
    endfunction

    task automatic drv(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.mem_ack  = ack;
    endtask

    // One clock: check the presented state, update the model, advance, check exceptions.
    task automatic tick();
        exp_t e;
        logic lg;
        logic acc;
        logic exc_next;
        acc = bus.in_valid && (mcount < DEPTH);
        chk("in_ready", bus.in_ready, mcount < DEPTH);
        chk("mem_req",  bus.mem_req,  mcount != 0);
        chk("empty",    bus.empty,    mcount == 0);
        if (mcount != 0) begin
            chk("mem_addr",  bus.mem_addr,  sb[0].addr);
            chk("mem_wdata", bus.mem_wdata, sb[0].wdata);
            chk("mem_be",    bus.mem_be,    sb[0].be);
            if (bus.mem_ack) begin
                void'(sb.pop_front());
            end
        end
        lg       = model(bus.in_op, bus.in_addr, bus.in_data, e);
        exc_next = acc && !lg;
        if (acc && lg) begin
            sb.push_back(e);
        end
        if (exc_next) begin
            exp_exc_addr = bus.in_addr;
        end
        exp_exc = exc_next;
        mcount  = sb.size();
        @(posedge clk);
        @(negedge clk);
        chk("exc_ades", bus.exc_ades, exp_exc);
        chk("exc_addr", bus.exc_addr, exp_exc_addr);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        mcount       = 0;
        exp_exc      = 1'b0;
        exp_exc_addr = 32'h0;
        reset        = 1'b0;
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_mem_req",   bus.mem_req,   0);
        chk("rst_mem_addr",  bus.mem_addr,  0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_be",    bus.mem_be,    0);
        chk("rst_exc_ades",  bus.exc_ades,  0);
        chk("rst_exc_addr",  bus.exc_addr,  0);
        chk("rst_empty",     bus.empty,     1);
        reset = 1'b1;
        @(negedge clk);

        // sw with immediate ack
        drv(1'b1, 2'b00, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);                tick(); tick();

        // sb to lane 3
        drv(1'b1, 2'b10, 32'h0000_2003, 32'h1234_56AB, 1'b1); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);                tick(); tick();

        // sh upper half, then a misaligned sh while the first drains
        drv(1'b1, 2'b01, 32'h0000_3002, 32'hFFFF_8001, 1'b1); tick();
        drv(1'b1, 2'b01, 32'h0000_3001, 32'h0000_5555, 1'b1); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);                tick();

        // back-to-back faults: misaligned sw then reserved op
        drv(1'b1, 2'b00, 32'h0000_4002, 32'h1111_1111, 1'b1); tick();
        drv(1'b1, 2'b11, 32'h0000_4000, 32'h2222_2222, 1'b1); tick();
        drv(1'b1, 2'b01, 32'h0000_4004, 32'hABCD_1357, 1'b1); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);                tick(); tick();

        // fill with ack low; third push refused; hold; single-cycle ack
        drv(1'b1, 2'b00, 32'h0000_5000, 32'hA000_0001, 1'b0); tick();
        drv(1'b1, 2'b00, 32'h0000_5004, 32'hB000_0002, 1'b0); tick();
        drv(1'b1, 2'b00, 32'h0000_5008, 32'hC000_0003, 1'b0); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);                tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);                tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);                tick();

        // refill, then valid and ack high together across the pointer wrap
        drv(1'b1, 2'b10, 32'h0000_6001, 32'h0000_00D1, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 2'(i % 3), 32'h0000_7000 + 32'(i * 4), 32'h0102_0300 + 32'(i), 1'b1);
            tick();
        end
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // reset mid-operation with two entries queued
        drv(1'b1, 2'b00, 32'h0000_8000, 32'h8888_0000, 1'b0); tick();
        drv(1'b1, 2'b01, 32'h0000_8006, 32'h0000_9999, 1'b0); tick();
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_req",  bus.mem_req,  0);
        chk("arst_empty",    bus.empty,    1);
        chk("arst_in_ready", bus.in_ready, 1);
        sb.delete();
        mcount       = 0;
        exp_exc      = 1'b0;
        exp_exc_addr = 32'h0;
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_store_packer
`default_nettype wire
